// File: rtl/alu_pkg.sv
// Shared ALU operation codes and RV32 opcode constants, used by the issue stage and the ALU.
package alu_pkg;

    typedef logic [6:0] alu_op_t;

    localparam alu_op_t ALU_ADD    = 7'd0;
    localparam alu_op_t ALU_SUB    = 7'd1;
    localparam alu_op_t ALU_SLL    = 7'd2;
    localparam alu_op_t ALU_SLT    = 7'd3;
    localparam alu_op_t ALU_SLTU   = 7'd4;
    localparam alu_op_t ALU_XOR    = 7'd5;
    localparam alu_op_t ALU_SRL    = 7'd6;
    localparam alu_op_t ALU_SRA    = 7'd7;
    localparam alu_op_t ALU_OR     = 7'd8;
    localparam alu_op_t ALU_AND    = 7'd9;
    localparam alu_op_t ALU_PASS_B = 7'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32 integer decode: instruction -> ALU operands, operation, rd and illegal flag.
module alu_issue_decode
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [6:0]      operation,
    output logic [4:0]      rd,
    output logic            illegal
);

    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic [6:0]             funct7;
    logic signed [XLEN-1:0] i_imm;
    logic signed [XLEN-1:0] u_imm;
    logic [XLEN-1:0]        shamt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign i_imm  = XLEN'($signed(instr[31:20]));
    assign u_imm  = XLEN'($signed({instr[31:12], 12'b0}));
    assign shamt  = XLEN'(instr[24:20]);

    always_comb begin
        a         = '0;
        b         = '0;
        operation = ALU_ADD;
        rd        = instr[11:7];
        illegal   = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    a = rs1_val;
                    b = rs2_val;
                    case (funct3)
                        3'b000:  operation = funct7[5] ? ALU_SUB : ALU_ADD;
                        3'b001:  operation = ALU_SLL;
                        3'b010:  operation = ALU_SLT;
                        3'b011:  operation = ALU_SLTU;
                        3'b100:  operation = ALU_XOR;
                        3'b101:  operation = funct7[5] ? ALU_SRA : ALU_SRL;
                        3'b110:  operation = ALU_OR;
                        default: operation = ALU_AND;
                    endcase
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                a = rs1_val;
                b = i_imm;
                case (funct3)
                    3'b000:  operation = ALU_ADD;
                    3'b001: begin
                        operation = ALU_SLL;
                        b         = shamt;
                    end
                    3'b010:  operation = ALU_SLT;
                    3'b011:  operation = ALU_SLTU;
                    3'b100:  operation = ALU_XOR;
                    3'b101: begin
                        operation = funct7[5] ? ALU_SRA : ALU_SRL;
                        b         = shamt;
                    end
                    3'b110:  operation = ALU_OR;
                    default: operation = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                operation = ALU_PASS_B;
                b         = u_imm;
            end
            OPC_AUIPC: begin
                a = pc;
                b = u_imm;
            end
            default: illegal = 1'b1;
        endcase
        // Illegal encodings issue as a harmless ADD 0+0 into x0.
        if (illegal) begin
            a         = '0;
            b         = '0;
            operation = ALU_ADD;
            rd        = '0;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decode, one-entry operand register with valid/ready handshake and flush.
// Optional writeback bypass enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [6:0]      operation,
    output logic [4:0]      rd,
    output logic            illegal,
    input  logic            flush,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

    logic            vld_p1;
    logic [XLEN-1:0] a_p1, b_p1;
    logic [6:0]      op_p1;
    logic [4:0]      rd_p1;
    logic            ill_p1;

    logic [XLEN-1:0] rs1_val_p0, rs2_val_p0;
    logic [XLEN-1:0] a_p0, b_p0;
    logic [6:0]      op_p0;
    logic [4:0]      rd_p0;
    logic            ill_p0;
    logic            accept_p0;

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

`ifdef ALU_ISSUE_FWD_EN
    assign rs1_val_p0 = (wb_valid && wb_rd == rs1_addr && wb_rd != 5'd0) ? wb_data : rs1_data;
    assign rs2_val_p0 = (wb_valid && wb_rd == rs2_addr && wb_rd != 5'd0) ? wb_data : rs2_data;
`else
    logic unused_wb;
    assign unused_wb  = ^{wb_valid, wb_rd, wb_data};
    assign rs1_val_p0 = rs1_data;
    assign rs2_val_p0 = rs2_data;
`endif

    alu_issue_decode #(.XLEN(XLEN)) u_decode (
        .instr     (in_instr),
        .pc        (in_pc),
        .rs1_val   (rs1_val_p0),
        .rs2_val   (rs2_val_p0),
        .a         (a_p0),
        .b         (b_p0),
        .operation (op_p0),
        .rd        (rd_p0),
        .illegal   (ill_p0)
    );

    assign in_ready  = (vld_p1 == EMPTY) || out_ready;
    assign accept_p0 = in_valid && in_ready;

    // p0 -> p1: operand register; flush wins over a same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= EMPTY;
            a_p1   <= '0;
            b_p1   <= '0;
            op_p1  <= ALU_ADD;
            rd_p1  <= '0;
            ill_p1 <= 1'b0;
        end else begin
            if (flush)
                vld_p1 <= EMPTY;
            else if (accept_p0)
                vld_p1 <= FULL;
            else if (out_ready)
                vld_p1 <= EMPTY;
            if (accept_p0 && !flush) begin
                a_p1   <= a_p0;
                b_p1   <= b_p0;
                op_p1  <= op_p0;
                rd_p1  <= rd_p0;
                ill_p1 <= ill_p0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign a         = a_p1;
    assign b         = b_p1;
    assign operation = op_p1;
    assign rd        = rd_p1;
    assign illegal   = ill_p1;

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue; expectations follow ALU_ISSUE_FWD_EN when defined.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a, b;
    logic [6:0]  operation;
    logic [4:0]  rd;
    logic        illegal;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .operation (operation),
        .rd        (rd),
        .illegal   (illegal),
        .flush     (flush),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] ea,
                             input logic [31:0] eb, input logic [6:0] eop,
                             input logic [4:0] erd, input logic eill);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".a"}, a, ea);
        check({tag, ".b"}, b, eb);
        check({tag, ".op"}, 32'(operation), 32'(eop));
        check({tag, ".rd"}, 32'(rd), 32'(erd));
        check({tag, ".illegal"}, 32'(illegal), 32'(eill));
    endtask

    initial begin
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0000_0013;
        in_pc     = 32'h0;
        rs1_data  = 32'h0;
        rs2_data  = 32'h0;
        out_ready = 1'b1;
        flush     = 1'b0;
        wb_valid  = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'h0;

        #2;
        check_out("reset", 1'b0, 32'h0, 32'h0, 7'd0, 5'd0, 1'b0);
        check("reset.in_ready", 32'(in_ready), 32'h1);
        #10 rst_n = 1'b1;

        // R-type add x3 = x1 + x2
        in_instr = 32'h0020_81B3;
        rs1_data = 32'd10;
        rs2_data = 32'd20;
        in_valid = 1'b1;
        #1;
        check("addr.rs1", 32'(rs1_addr), 32'd1);
        check("addr.rs2", 32'(rs2_addr), 32'd2);
        tick();
        check_out("radd", 1'b1, 32'd10, 32'd20, 7'd0, 5'd3, 1'b0);

        // addi x1, x0, 5 issued back to back
        in_instr = 32'h0050_0093;
        rs1_data = 32'd0;
        rs2_data = 32'd99;
        tick();
        check_out("addi", 1'b1, 32'd0, 32'd5, 7'd0, 5'd1, 1'b0);

        // lui x5, 0x12345
        in_instr = 32'h1234_52B7;
        in_pc    = 32'h100;
        rs1_data = 32'hDEAD;
        tick();
        check_out("lui", 1'b1, 32'd0, 32'h1234_5000, 7'd10, 5'd5, 1'b0);

        // srai x1, x1, 3
        in_instr = 32'h4030_D093;
        rs1_data = 32'h80;
        tick();
        check_out("srai", 1'b1, 32'h80, 32'd3, 7'd7, 5'd1, 1'b0);

        // addi with negative immediate -1 sign-extends
        in_instr = 32'hFFF0_8113;
        rs1_data = 32'd4;
        tick();
        check_out("addi_neg", 1'b1, 32'd4, 32'hFFFF_FFFF, 7'd0, 5'd2, 1'b0);

        // auipc x2, 0x1
        in_instr = 32'h0000_1117;
        tick();
        check_out("auipc", 1'b1, 32'h100, 32'h1000, 7'd0, 5'd2, 1'b0);

        // all-ones: unknown opcode
        in_instr = 32'hFFFF_FFFF;
        rs1_data = 32'h1234;
        rs2_data = 32'h5678;
        tick();
        check_out("ill_ones", 1'b1, 32'h0, 32'h0, 7'd0, 5'd0, 1'b1);

        // R-type with funct7=0000001 is illegal here
        in_instr = 32'h0220_81B3;
        tick();
        check_out("ill_f7", 1'b1, 32'h0, 32'h0, 7'd0, 5'd0, 1'b1);

        // sub x3 = x1 - x2
        in_instr = 32'h4020_81B3;
        rs1_data = 32'd30;
        rs2_data = 32'd5;
        tick();
        check_out("sub", 1'b1, 32'd30, 32'd5, 7'd1, 5'd3, 1'b0);

        // backpressure: xor offered while SUB is held
        out_ready = 1'b0;
        in_instr  = 32'h0020_C1B3;
        rs1_data  = 32'd6;
        rs2_data  = 32'd3;
        #1;
        check("bp.in_ready", 32'(in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("bp_hold", 1'b1, 32'd30, 32'd5, 7'd1, 5'd3, 1'b0);
            check("bp_hold.in_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release.in_ready", 32'(in_ready), 32'h1);
        tick();
        check_out("bp_xor", 1'b1, 32'd6, 32'd3, 7'd5, 5'd3, 1'b0);

        // flush concurrent with an accepted transfer
        in_instr = 32'h0020_81B3;
        flush    = 1'b1;
        tick();
        check("flush.valid", 32'(out_valid), 32'h0);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("flush_idle.valid", 32'(out_valid), 32'h0);

        // writeback bypass onto rs1
        in_valid = 1'b1;
        in_instr = 32'h0020_81B3;
        rs1_data = 32'd7;
        rs2_data = 32'd20;
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        wb_data  = 32'h55;
`ifdef ALU_ISSUE_FWD_EN
        exp_a = 32'h55;
`else
        exp_a = 32'd7;
`endif
        tick();
        check_out("fwd_rs1", 1'b1, exp_a, 32'd20, 7'd0, 5'd3, 1'b0);

        // bypass onto rs2
        wb_rd = 5'd2;
`ifdef ALU_ISSUE_FWD_EN
        exp_b = 32'h55;
`else
        exp_b = 32'd20;
`endif
        tick();
        check_out("fwd_rs2", 1'b1, 32'd7, exp_b, 7'd0, 5'd3, 1'b0);

        // wb_rd = x0 never bypasses (addi x1, x0, 0)
        in_instr = 32'h0000_0093;
        wb_rd    = 5'd0;
        tick();
        check_out("fwd_x0", 1'b1, 32'd7, 32'd0, 7'd0, 5'd1, 1'b0);
        wb_valid = 1'b0;

        // asynchronous reset while FULL
        in_instr = 32'h0020_81B3;
        rs1_data = 32'd11;
        rs2_data = 32'd22;
        tick();
        check("prerst.valid", 32'(out_valid), 32'h1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 32'h0, 32'h0, 7'd0, 5'd0, 1'b0);
        #1 rst_n = 1'b1;
        tick();
        check("postrst.valid", 32'(out_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1, in_instr input 32, in_pc input XLEN: decoded-stage instruction handshake.
REQ-005 SHALL have ports rs1_addr output 5, rs2_addr output 5 (combinational from in_instr), rs1_data input XLEN, rs2_data input XLEN (same-cycle register file read).
REQ-006 SHALL have ports out_valid output 1, out_ready input 1, a output XLEN, b output XLEN, operation output 7, rd output 5, illegal output 1: registered ALU operands.
REQ-007 SHALL have port flush input 1, which discards the held operation.
REQ-008 SHALL have ports wb_valid input 1, wb_rd input 5, wb_data input XLEN: writeback bypass (used only under REQ-021).

Function
REQ-009 SHALL implement a two-state machine: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-010 SHALL drive in_ready = !out_valid || out_ready, with no combinational path from in_valid.
REQ-011 SHALL accept on in_valid && in_ready, registering a, b, operation, rd and illegal; out_valid rises the next cycle (latency 1).
REQ-012 SHALL accept and drain in the same cycle when FULL and out_ready=1, giving back-to-back throughput of 1 per cycle.
REQ-013 SHALL hold a, b, operation, rd and illegal stable while out_valid && !out_ready.
REQ-014 SHALL decode R-type (0110011) with a=rs1, b=rs2, op from funct3/funct7[5].
REQ-015 SHALL decode OP-IMM (0010011) with a=rs1, b=sign-extended imm[11:0]; shifts use b=shamt zero-extended and funct7[5] selects SRA.
REQ-016 SHALL decode LUI with op=PASS_B, b={imm[31:12],12'b0}, a=0.
REQ-017 SHALL decode AUIPC with op=ADD, a=in_pc, b={imm[31:12],12'b0}.
REQ-018 SHALL treat any other opcode, or an R-type funct7 other than 0000000/0100000, as illegal: illegal=1, op=ADD, a=b=0, rd=0.
REQ-019 SHALL give flush priority over accept: flush=1 forces EMPTY next cycle, including when a transfer is offered in the same cycle.

Reset
REQ-020 SHALL, on rst_n=0, immediately clear out_valid=0, a=0, b=0, operation=ADD, rd=0 and illegal=0; state returns to EMPTY and any held operation is lost.

Configuration
REQ-021 SHALL, with ALU_ISSUE_FWD_EN defined, replace rs1_data (and likewise rs2_data) with wb_data when wb_valid && wb_rd==rs1_addr && wb_rd!=0; without the macro, wb_* ports exist but are ignored.

Structure
REQ-022 SHALL take the 7-bit ALU operation codes from a shared package alu_pkg, also used by the ALU: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10.
REQ-023 SHALL place the RV32 opcode constants in the same shared package, alu_pkg.
REQ-024 SHALL implement decode as a purely combinational sub-module alu_issue_decode; the top level holds the handshake, the register stage and the bypass.

Verification
REQ-025 SHALL cover R-type add: in_instr=0x002081B3, rs1_data=10, rs2_data=20 -> next cycle out_valid=1, a=10, b=20, op=ADD, rd=3.
REQ-026 SHALL cover immediates: 0x00500093 -> a=0, b=5, op=ADD; 0x123452B7 -> op=PASS_B, b=0x12345000; 0x4030D093 -> op=SRA, b=3.
REQ-027 SHALL cover backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0 and outputs unchanged; out_ready=1 -> next operation issued in the same cycle.
REQ-028 SHALL cover flush: flush=1 concurrent with an accepted transfer -> out_valid=0 next cycle; rst_n=0 while FULL -> out_valid=0 immediately.
REQ-029 SHALL cover forwarding (ALU_ISSUE_FWD_EN): wb_valid=1, wb_rd=1, wb_data=0x55, rs1_data=7 for 0x002081B3 -> a=0x55; with wb_rd=0 -> no bypass; without the macro -> a=7.
REQ-030 SHALL cover illegal input: in_instr=0xFFFFFFFF -> illegal=1, op=ADD, a=b=0, rd=0.
